// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes in1 - in2 - b_in one bit per clock, LSB first,
// and presents the difference, borrow-out, zero and overflow flags at completion.
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             bit_a_s;
    logic             bit_b_s;
    logic             d_bit_s;
    logic             br_nxt_s;
    logic [WIDTH-1:0] res_nxt_s;

    // One full-subtractor slice operating on the current LSBs of the operand shifters.
    always_comb begin
        bit_a_s   = a_q[0];
        bit_b_s   = b_q[0];
        d_bit_s   = bit_a_s ^ bit_b_s ^ br_q;
        br_nxt_s  = (~bit_a_s & bit_b_s) | (~(bit_a_s ^ bit_b_s) & br_q);
        res_nxt_s = {d_bit_s, r_q[WIDTH-1:1]};
    end

    // Next-state, datapath and result-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        br_d    = br_q;
        diff_d  = diff_q;
        b_out_d = b_out_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = {CW{1'b0}};
                    a_d     = in1;
                    b_d     = in2;
                    r_d     = {WIDTH{1'b0}};
                    br_d    = b_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d  = {1'b0, a_q[WIDTH-1:1]};
                b_d  = {1'b0, b_q[WIDTH-1:1]};
                r_d  = res_nxt_s;
                br_d = br_nxt_s;
                if (cnt_q == LAST_BIT) begin
                    // On the last bit a/b LSBs are the original MSBs, needed for overflow.
                    state_d = ST_DONE;
                    diff_d  = res_nxt_s;
                    b_out_d = br_nxt_s;
                    zero_d  = (res_nxt_s == {WIDTH{1'b0}});
                    ovf_d   = (bit_a_s != bit_b_s) && (d_bit_s != bit_a_s);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            r_q     <= {WIDTH{1'b0}};
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= {WIDTH{1'b0}};
            b_out_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            br_q    <= br_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            b_out_q <= b_out_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign b_out = b_out_q;
    assign zero  = zero_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=32): vector table
// plus hand-written sequences for mid-run start, held start and mid-run reset.
module tb_serial_subtractor;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         b_out;
    logic         zero;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] d;
        logic         bo;
        logic         z;
        logic         o;
    } vec_t;

    vec_t vecs [9];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, optionally re-pulse start mid-run, and check timing and results.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input int glitch, input logic [W-1:0] ed, input logic eb,
                          input logic ez, input logic eo, input string tag);
        int   n;
        logic seen;
        logic busy_ok;
        start = 1'b1; in1 = a; in2 = b; b_in = bi;
        step();
        start = 1'b0; in1 = ~a; in2 = ~b; b_in = ~bi;
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && n < 40) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                start = (n == glitch) ? 1'b1 : 1'b0;
                step();
                n++;
            end
        end
        start = 1'b0;
        chk({tag, " done_seen"}, 64'(seen), 64'd1);
        chk({tag, " latency"}, 64'(n), 64'd32);
        chk({tag, " busy_during_run"}, 64'(busy_ok), 64'd1);
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, " diff"}, 64'(diff), 64'(ed));
        chk({tag, " flags b_out/zero/ovf"}, 64'({b_out, zero, ovf}), 64'({eb, ez, eo}));
        step();
        chk({tag, " done_one_cycle"}, 64'({busy, done}), 64'd0);
        chk({tag, " diff_held"}, 64'(diff), 64'(ed));
    endtask

    initial begin
        int   n;
        int   period;
        int   bad;
        logic seen;

        vecs[0] = '{32'h0000000A, 32'h00000003, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h12345678, 32'h12345677, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{32'hDEADBEEF, 32'h12345678, 1'b0, 32'hCC796877, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0; b_in = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_outputs", 64'({busy, done, b_out, zero, ovf, diff}), 64'd0);
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", 64'({busy, done, diff}), 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bi, -1, vecs[i].d,
                   vecs[i].bo, vecs[i].z, vecs[i].o, $sformatf("vec%0d", i));
        end

        // Start re-pulsed mid-run with other operands must be ignored.
        run_op(32'h0000000A, 32'h00000003, 1'b0, 5, 32'h00000007, 1'b0, 1'b0, 1'b0, "midrun_start");

        // Start held high: back-to-back operations with a 33-cycle done period.
        start = 1'b1; in1 = 32'h00000005; in2 = 32'h00000003; b_in = 1'b0;
        step();
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk("held first_latency", 64'(n), 64'd32);
        chk("held first_diff", 64'(diff), 64'd2);
        period = 0; seen = 1'b0; bad = 0;
        while (!seen && period < 40) begin
            step();
            period++;
            if (done) seen = 1'b1;
            else if (!busy) bad++;
        end
        chk("held period", 64'(period), 64'd33);
        chk("held busy_between", 64'(bad), 64'd0);
        chk("held second_diff", 64'(diff), 64'd2);
        start = 1'b0;
        step();
        chk("held release_idle", 64'({busy, done}), 64'd0);

        // Reset during RUN: immediate clear and no later done pulse.
        start = 1'b1; in1 = 32'h0000000A; in2 = 32'h00000003; b_in = 1'b0;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("rst busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst async_clear", 64'({busy, done, b_out, zero, ovf, diff}), 64'd0);
        step();
        #2;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done || busy) bad++;
        end
        chk("rst no_done_after_abort", 64'(bad), 64'd0);
        run_op(32'h12345678, 32'h12345677, 1'b1, -1, 32'h00000000, 1'b0, 1'b1, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
